// File: rtl/gl_cmd_writer.sv
// Packs host command words into the instruction BRAM, one registered write per accepted word (1-cycle latency).
// Backpressure: in_ready drops when the next opcode's whole packet would not fit, and stays low until flush or reset.
module gl_cmd_writer #(
    parameter int width      = 32,
    parameter int text_start = 0,
    parameter int depth      = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             wr_en,
    output logic [width-1:0] wr_addr,
    output logic [width-1:0] wr_data,
    output logic             pkt_done,
    output logic [width-1:0] commit_addr,
    output logic [15:0]      pkt_count,
    output logic             full
);

    typedef enum logic [1:0] {S_OPCODE, S_PAYLOAD, S_FULL} state_t;

    localparam logic [width-1:0] LP_START = width'(text_start);
    localparam logic [width:0]   LP_END   = (width+1)'(text_start) + (width+1)'(depth);
    localparam logic [width:0]   LP_INC   = (width+1)'(1);
    localparam logic [width-1:0] LP_ONE   = width'(1);

    state_t           r_state;
    logic [4:0]       r_rem;
    logic [width:0]   r_wptr;
    logic             r_live;
    logic             r_wr_en;
    logic [width-1:0] r_wr_addr;
    logic [width-1:0] r_wr_data;
    logic             r_pkt_done;
    logic [width-1:0] r_commit;
    logic [15:0]      r_count;
    logic             r_full;

    logic [4:0]       w_len;
    logic [width:0]   w_need;
    logic             w_fits;
    logic             w_ready;
    logic             w_acc;
    logic             w_last;

    always_comb begin
        w_len = 5'd1;
        case (in_data[7:0])
            8'h03, 8'h04:                      w_len = 5'd4;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: w_len = 5'd17;
            8'h19:                             w_len = 5'd5;
            8'h1A:                             w_len = 5'd7;
            default:                           w_len = 5'd1;
        endcase
    end

    // The write pointer carries one extra bit so the fit test cannot be fooled by a wrap.
    assign w_need  = r_wptr + (width+1)'(w_len);
    assign w_fits  = (w_need <= LP_END);
    assign w_ready = r_live && !flush &&
                     ((r_state == S_PAYLOAD) || ((r_state == S_OPCODE) && w_fits));
    assign w_acc   = in_valid && w_ready;
    assign w_last  = ((r_state == S_PAYLOAD) && (r_rem == 5'd1)) ||
                     ((r_state == S_OPCODE) && (w_len == 5'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_OPCODE;
            r_rem      <= 5'd0;
            r_wptr     <= {1'b0, LP_START};
            r_live     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= LP_START;
            r_wr_data  <= '0;
            r_pkt_done <= 1'b0;
            r_commit   <= LP_START;
            r_count    <= 16'd0;
            r_full     <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_wr_en    <= 1'b0;
            r_pkt_done <= 1'b0;
            if (flush) begin
                r_state  <= S_OPCODE;
                r_rem    <= 5'd0;
                r_wptr   <= {1'b0, LP_START};
                r_commit <= LP_START;
                r_count  <= 16'd0;
                r_full   <= 1'b0;
            end else begin
                if (w_acc) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_wptr[width-1:0];
                    r_wr_data <= in_data;
                    r_wptr    <= r_wptr + LP_INC;
                    if (w_last) begin
                        r_pkt_done <= 1'b1;
                        r_commit   <= r_wptr[width-1:0] + LP_ONE;
                        r_count    <= r_count + 16'd1;
                    end
                end
                case (r_state)
                    S_OPCODE: begin
                        if (w_acc && (w_len != 5'd1)) begin
                            r_rem   <= w_len - 5'd1;
                            r_state <= S_PAYLOAD;
                        end else if (in_valid && r_live && !w_fits) begin
                            r_state <= S_FULL;
                            r_full  <= 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_acc) begin
                            r_rem <= r_rem - 5'd1;
                            if (r_rem == 5'd1) r_state <= S_OPCODE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready    = w_ready;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign pkt_done    = r_pkt_done;
    assign commit_addr = r_commit;
    assign pkt_count   = r_count;
    assign full        = r_full;

endmodule

// File: doc/gl_cmd_writer.md
GL_CMD_WRITER -- requirements
Module: gl_cmd_writer

Interface
REQ-001 SHALL have parameter: width, 32, data and address width.
REQ-002 SHALL have parameter: text_start, 0, first instruction BRAM word address.
REQ-003 SHALL have parameter: depth, 1024, instruction BRAM size in words.
REQ-004 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: in_data  input  width  host command word (opcode word or operand word).
REQ-007 SHALL have port: in_valid  input  1  in_data valid.
REQ-008 SHALL have port: in_ready  output  1  writer accepts in_data this cycle.
REQ-009 SHALL have port: flush  input  1  synchronous restart of the command buffer.
REQ-010 SHALL have port: wr_en  output  1  instruction BRAM write strobe.
REQ-011 SHALL have port: wr_addr  output  width  instruction BRAM write address.
REQ-012 SHALL have port: wr_data  output  width  instruction BRAM write data.
REQ-013 SHALL have port: pkt_done  output  1  one-cycle pulse, a complete packet has been written.
REQ-014 SHALL have port: commit_addr  output  width  address one past the last complete packet; fetch reads only below it.
REQ-015 SHALL have port: pkt_count  output  16  complete packets written since reset/flush, wraps at 2^16.
REQ-016 SHALL have port: full  output  1  buffer cannot hold the pending packet; sticky until flush/reset.

Function
REQ-017 SHALL accept a word when in_valid and in_ready are both 1 at a posedge.
REQ-018 SHALL implement states S_OPCODE (next word is an opcode), S_PAYLOAD (operand words remain), S_FULL.
REQ-019 SHALL, on an accepted word in S_OPCODE, derive total packet length L from in_data[7:0]: 0x03->4, 0x04->4, 0x11->17, 0x13->17, 0x16->17, 0x17->17, 0x18->17, 0x19->5, 0x1A->7, all others->1.
REQ-020 SHALL, in S_OPCODE, check fit before accepting: if next write address + L > text_start + depth, hold in_ready 0, enter S_FULL, set full, write nothing.
REQ-021 SHALL, on an accepted fitting opcode with L=1, stay in S_OPCODE and complete the packet; with L>1, load remaining counter with L-1 and enter S_PAYLOAD.
REQ-022 SHALL, in S_PAYLOAD, decrement remaining per accepted word and return to S_OPCODE when the last operand is accepted; payload words are never decoded as opcodes.
REQ-023 SHALL drive in_ready = 1 in S_OPCODE (subject to REQ-020) and S_PAYLOAD, 0 in S_FULL and during any cycle flush is 1.
REQ-024 SHALL register writes: a word accepted at edge N yields wr_en=1, wr_data=that word, wr_addr=consecutive address at edge N+1 for exactly one cycle; wr_en=0 otherwise.
REQ-025 SHALL assign addresses sequentially from text_start with no gaps; no wrap-around (overflow handled by REQ-020).
REQ-026 SHALL pulse pkt_done, advance commit_addr to wr_addr+1, and increment pkt_count in the same cycle wr_en writes the last word of a packet.
REQ-027 SHALL tolerate in_valid gaps anywhere in a packet with no state change while in_valid=0.
REQ-028 SHALL, on flush=1 at a posedge, take priority over any accept: state S_OPCODE, write pointer and commit_addr to text_start, pkt_count 0, full 0, pending registered write discarded (wr_en 0 next cycle); a partial packet is dropped and commit_addr never covers it.

Reset
REQ-029 SHALL, while reset=0, asynchronously force: state S_OPCODE, wr_en 0, wr_addr text_start, wr_data 0, pkt_done 0, commit_addr text_start, pkt_count 0, full 0, in_ready 0.
REQ-030 SHALL drop a partial packet on reset mid-packet; the first word after reset release is treated as an opcode.
REQ-031 SHALL assert in_ready no earlier than the first posedge after reset deasserts.

Verification
REQ-032 SHALL cover: VERTEX 0x00000003 + 3 operands back-to-back -> writes at addr 0..3 on consecutive cycles, pkt_done with the addr-3 write, commit_addr=4, pkt_count=1.
REQ-033 SHALL cover: MULTMATRIX 0x11 + 16 operands with in_valid low every other cycle -> 17 writes at 0..16, payload word 0x00000003 not decoded, commit_addr=17.
REQ-034 SHALL cover: unknown opcode 0x00000001 x3 -> three 1-word packets, three pkt_done pulses, commit_addr=3, pkt_count=3.
REQ-035 SHALL cover: depth=8, write VIEWPORT (5 words) then FRUSTUM 0x1A -> FRUSTUM refused, in_ready 0, full 1, commit_addr=5, no write at addr 5.
REQ-036 SHALL cover: reset pulled low after 2 of 4 COLOR words -> outputs at reset values immediately, commit_addr=0; next packet starts at addr 0.
REQ-037 SHALL cover: flush asserted with in_valid=1 mid-LOADMATRIX and in full state -> no accept that cycle, full 0, commit_addr=0, pkt_count=0, next write at addr 0.
